// File: rtl/riscv_pkg.sv
// Shared CSR-stage types: access opcodes, privilege levels, counter sizing.
package riscv;

  typedef logic [11:0] csr_reg_t;

  typedef enum logic [1:0] {
    CSR_READ  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_lvl_t;

  localparam int unsigned NB_HPM_EVENTS = 14;

endpackage

// File: rtl/csr_perf_counters_perf_counter.sv
// Single free-running counter; a CSR write replaces the value and
// suppresses that cycle's increment.
module perf_counter #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN-1:0] cnt_d, cnt_q;

  // Next value: write beats increment; natural wrap at 2^XLEN.
  always_comb begin
    cnt_d = cnt_q;
    if (we_i) begin
      cnt_d = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register; reset also discards a write issued in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/csr_perf_counters.sv
// Machine counter / HPM CSR bank (0xB00-0xB1F) with user read-only shadows
// (0xC00-0xC1F). Responds one cycle after each request with the pre-access value.
module csr_perf_counters #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned NB_HPM_EVENTS = 14,
  parameter int unsigned NB_RESERVED   = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     csr_valid_i,
  input  logic [11:0]              csr_addr_i,
  input  logic [1:0]               csr_op_i,
  input  logic [XLEN-1:0]          csr_wdata_i,
  input  logic [1:0]               priv_lvl_i,
  input  logic [31:0]              mcounteren_i,
  input  logic                     instret_i,
  input  logic [NB_HPM_EVENTS-1:0] event_i,
  output logic                     csr_rvalid_o,
  output logic [XLEN-1:0]          csr_rdata_o,
  output logic                     csr_illegal_o
);
  import riscv::*;

  // Counter 0 = mcycle, 1 = minstret, 2.. = event counters.
  localparam int unsigned NB_CNT   = NB_HPM_EVENTS + 2;
  localparam int unsigned NB_SLOTS = 3 + NB_HPM_EVENTS + NB_RESERVED;
  localparam logic [6:0]  M_PAGE   = 7'h58;  // 0xB00 >> 5
  localparam logic [6:0]  U_PAGE   = 7'h60;  // 0xC00 >> 5

  // Read-modify-write result for write/set/clear; read leaves the value alone.
  function automatic logic [XLEN-1:0] csr_update(input logic [1:0] op,
                                                 input logic [XLEN-1:0] old_val,
                                                 input logic [XLEN-1:0] operand);
    case (op)
      CSR_WRITE: csr_update = operand;
      CSR_SET:   csr_update = old_val | operand;
      CSR_CLEAR: csr_update = old_val & ~operand;
      default:   csr_update = old_val;
    endcase
  endfunction

  logic [XLEN-1:0]   cnt_q [NB_CNT];
  logic [NB_CNT-1:0] cnt_inc, cnt_we, cnt_sel;
  logic [XLEN-1:0]   cnt_wdata, rd_val;
  logic [4:0]        slot;
  logic              is_m_page, is_u_page, is_priv_m, op_is_read, illegal;

  logic            rvalid_d, rvalid_q;
  logic            illegal_d, illegal_q;
  logic [XLEN-1:0] rdata_d, rdata_q;

  // Address decode, legality, read mux and write-enable generation.
  always_comb begin
    slot       = csr_addr_i[4:0];
    is_m_page  = (csr_addr_i[11:5] == M_PAGE);
    is_u_page  = (csr_addr_i[11:5] == U_PAGE);
    is_priv_m  = (priv_lvl_i == PRIV_M);
    op_is_read = (csr_op_i == CSR_READ);

    // 0xC01 is the time CSR, served elsewhere; user shadows need mcounteren below M.
    illegal = !(is_m_page || is_u_page)
           || !(32'(slot) < NB_SLOTS)
           || (is_u_page && slot == 5'd1)
           || (is_m_page && !is_priv_m)
           || (is_u_page && !op_is_read)
           || (is_u_page && !is_priv_m && !mcounteren_i[slot]);

    cnt_sel    = '0;
    cnt_sel[0] = (slot == 5'd0);
    cnt_sel[1] = (slot == 5'd2);
    for (int k = 0; k < int'(NB_HPM_EVENTS); k++) begin
      cnt_sel[k+2] = (slot == 5'(k + 3));
    end

    // Slots without a counter (0xB01, reserved range) fall through as zero.
    rd_val = '0;
    for (int c = 0; c < int'(NB_CNT); c++) begin
      if (cnt_sel[c]) rd_val = cnt_q[c];
    end

    cnt_wdata = csr_update(csr_op_i, rd_val, csr_wdata_i);
    cnt_we    = (csr_valid_i && !illegal && is_m_page && !op_is_read) ? cnt_sel : '0;
    cnt_inc   = {event_i, instret_i, 1'b1};

    rvalid_d  = csr_valid_i;
    illegal_d = csr_valid_i && illegal;
    rdata_d   = (csr_valid_i && !illegal) ? rd_val : '0;
  end

  for (genvar g = 0; g < int'(NB_CNT); g++) begin : g_cnt
    perf_counter #(.XLEN(XLEN)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (cnt_inc[g]),
      .we_i    (cnt_we[g]),
      .wdata_i (cnt_wdata),
      .q_o     (cnt_q[g])
    );
  end

  // Response register: one-cycle access latency, dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q  <= 1'b0;
      illegal_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q  <= rvalid_d;
      illegal_q <= illegal_d;
      rdata_q   <= rdata_d;
    end
  end

  assign csr_rvalid_o  = rvalid_q;
  assign csr_illegal_o = illegal_q;
  assign csr_rdata_o   = rdata_q;

endmodule

// File: tb/tb_csr_perf_counters.sv
// Scoreboard bench for csr_perf_counters: a behavioural counter model predicts
// each response when the request is driven; responses are compared a cycle later.
module tb_csr_perf_counters;

  logic        clk;
  logic        rst;
  logic        csr_valid_i;
  logic [11:0] csr_addr_i;
  logic [1:0]  csr_op_i;
  logic [63:0] csr_wdata_i;
  logic [1:0]  priv_lvl_i;
  logic [31:0] mcounteren_i;
  logic        instret_i;
  logic [13:0] event_i;
  logic        csr_rvalid_o;
  logic [63:0] csr_rdata_o;
  logic        csr_illegal_o;

  csr_perf_counters dut (
    .clk           (clk),
    .rst           (rst),
    .csr_valid_i   (csr_valid_i),
    .csr_addr_i    (csr_addr_i),
    .csr_op_i      (csr_op_i),
    .csr_wdata_i   (csr_wdata_i),
    .priv_lvl_i    (priv_lvl_i),
    .mcounteren_i  (mcounteren_i),
    .instret_i     (instret_i),
    .event_i       (event_i),
    .csr_rvalid_o  (csr_rvalid_o),
    .csr_rdata_o   (csr_rdata_o),
    .csr_illegal_o (csr_illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ill;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_cnt [16];
  int          n_vec = 0;
  int          n_err = 0;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, ST = 2'b10, CL = 2'b11;
  localparam logic [1:0] PU = 2'b00, PS = 2'b01, PM = 2'b11;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: which of the 16 counters a 5-bit slot names, or -1.
  function automatic int m_idx(input logic [4:0] s);
    if (s == 5'd0) return 0;
    if (s == 5'd2) return 1;
    if (s >= 5'd3 && s <= 5'd16) return int'(s) - 1;
    return -1;
  endfunction

  function automatic logic m_legal(input logic [11:0] a, input logic [1:0] op,
                                   input logic [1:0] pv, input logic [31:0] mc);
    if (a[11:5] == 7'h58) return (pv == PM);
    if (a[11:5] == 7'h60) begin
      if (a[4:0] == 5'd1) return 1'b0;
      if (op != RD) return 1'b0;
      if (pv != PM && !mc[a[4:0]]) return 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: drive, predict, advance model, then compare the registered response.
  task automatic step(input logic v, input logic [11:0] a, input logic [1:0] op,
                      input logic [63:0] wd, input logic [1:0] pv, input logic [31:0] mc,
                      input logic ir, input logic [13:0] ev, input string tag);
    exp_t        e;
    logic [63:0] old_v, new_v;
    logic        leg, exp_rv;
    int          ix;
    @(negedge clk);
    csr_valid_i  = v;
    csr_addr_i   = a;
    csr_op_i     = op;
    csr_wdata_i  = wd;
    priv_lvl_i   = pv;
    mcounteren_i = mc;
    instret_i    = ir;
    event_i      = ev;
    exp_rv       = v && !rst;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_cnt[i] = '0;
    end else begin
      leg   = m_legal(a, op, pv, mc);
      ix    = m_idx(a[4:0]);
      old_v = (ix >= 0) ? m_cnt[ix] : 64'd0;
      if (v) begin
        e.ill  = !leg;
        e.data = leg ? old_v : 64'd0;
        sb.push_back(e);
      end
      m_cnt[0] = m_cnt[0] + 64'd1;
      if (ir) m_cnt[1] = m_cnt[1] + 64'd1;
      for (int k = 0; k < 14; k++) if (ev[k]) m_cnt[k+2] = m_cnt[k+2] + 64'd1;
      if (v && leg && a[11:5] == 7'h58 && op != RD && ix >= 0) begin
        case (op)
          WR:      new_v = wd;
          ST:      new_v = old_v | wd;
          default: new_v = old_v & ~wd;
        endcase
        m_cnt[ix] = new_v;
      end
    end
    @(posedge clk);
    #1;
    check_eq({tag, ".rvalid"}, {63'd0, csr_rvalid_o}, {63'd0, exp_rv});
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({tag, ".illegal"}, {63'd0, csr_illegal_o}, {63'd0, e.ill});
      check_eq({tag, ".rdata"}, csr_rdata_o, e.data);
    end else begin
      check_eq({tag, ".illegal0"}, {63'd0, csr_illegal_o}, 64'd0);
      check_eq({tag, ".rdata0"}, csr_rdata_o, 64'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'h000, RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "idle");
  endtask

  initial begin
    logic [11:0] ra;
    logic [1:0]  rop, rpv;
    rst = 1'b1;
    csr_valid_i = 1'b0; csr_addr_i = '0; csr_op_i = '0; csr_wdata_i = '0;
    priv_lvl_i = PM; mcounteren_i = '0; instret_i = 1'b0; event_i = '0;

    // Reset state
    idle(2);
    rst = 1'b0;

    // mcycle after 10 idle cycles, minstret untouched
    idle(10);
    step(1'b1, 12'hB00, RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "mcycle10");
    check_eq("mcycle10.abs", csr_rdata_o, 64'd10);
    step(1'b1, 12'hB02, RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "minstret0");
    check_eq("minstret0.abs", csr_rdata_o, 64'd0);

    // Write beats same-cycle increment, then wrap
    step(1'b1, 12'hB07, WR, 64'hFFFF_FFFF_FFFF_FFFF, PM, 32'd0, 1'b0, 14'h0031, "wr_b07");
    step(1'b1, 12'hB07, RD, 64'd0, PM, 32'd0, 1'b0, 14'h0010, "rd_b07_ones");
    check_eq("b07_ones.abs", csr_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 12'hB07, RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "rd_b07_wrap");
    check_eq("b07_wrap.abs", csr_rdata_o, 64'd0);

    // Set / clear returning old values
    step(1'b1, 12'hB0B, WR, 64'h0F, PM, 32'd0, 1'b0, 14'd0, "wr_b0b");
    step(1'b1, 12'hB0B, ST, 64'hF0, PM, 32'd0, 1'b0, 14'd0, "set_b0b");
    check_eq("set_b0b.old", csr_rdata_o, 64'h0F);
    step(1'b1, 12'hB0B, CL, 64'h03, PM, 32'd0, 1'b0, 14'd0, "clr_b0b");
    check_eq("clr_b0b.old", csr_rdata_o, 64'hFF);
    step(1'b1, 12'hB0B, RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "rd_b0b");
    check_eq("rd_b0b.abs", csr_rdata_o, 64'hFC);

    // User shadows gated by mcounteren
    for (int i = 0; i < 5; i++) step(1'b0, 12'h000, RD, 64'd0, PM, 32'd0, 1'b1, 14'd0, "instret");
    step(1'b1, 12'hC02, RD, 64'd0, PU, 32'h4, 1'b0, 14'd0, "u_c02_en");
    check_eq("u_c02_en.abs", csr_rdata_o, 64'd5);
    step(1'b1, 12'hC02, RD, 64'd0, PU, 32'h0, 1'b0, 14'd0, "u_c02_dis");
    step(1'b1, 12'hC00, RD, 64'd0, PS, 32'h1, 1'b0, 14'd0, "s_c00_en");

    // Illegal and reserved accesses
    step(1'b1, 12'hB00, RD, 64'd0, PU, 32'hFFFF_FFFF, 1'b0, 14'd0, "u_b00");
    step(1'b1, 12'hB00, RD, 64'd0, PS, 32'hFFFF_FFFF, 1'b0, 14'd0, "s_b00");
    step(1'b1, 12'hC00, WR, 64'd0, PM, 32'd0, 1'b0, 14'd0, "m_wr_c00");
    step(1'b1, 12'hB00, RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "mcycle_after");
    step(1'b1, 12'hC01, RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "m_c01");
    step(1'b1, 12'hB15, WR, 64'h55, PM, 32'd0, 1'b0, 14'd0, "wr_b15");
    step(1'b1, 12'hB15, RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "rd_b15");
    step(1'b1, 12'hB01, RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "rd_b01");
    step(1'b1, 12'hB20, RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "rd_b20");
    step(1'b1, 12'h300, RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "rd_300");

    // Random back-to-back traffic
    for (int i = 0; i < 60; i++) begin
      ra  = ($urandom_range(0, 1) == 0) ? 12'hB00 : 12'hC00;
      ra[4:0] = 5'($urandom_range(0, 31));
      rop = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : RD;
      case ($urandom_range(0, 3))
        0:       rpv = PU;
        1:       rpv = PS;
        default: rpv = PM;
      endcase
      step(1'($urandom_range(0, 3) != 0), ra, rop, {$urandom, $urandom}, rpv, $urandom,
           1'($urandom_range(0, 1)), 14'($urandom), "rand");
    end
    for (int s = 0; s < 17; s++)
      step(1'b1, 12'hB00 + 12'(s), RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "sweep");

    // Reset during a write
    rst = 1'b1;
    step(1'b1, 12'hB03, WR, 64'h1234, PM, 32'd0, 1'b1, 14'h3FFF, "rst_wr");
    rst = 1'b0;
    step(1'b1, 12'hB03, RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "post_rst_b03");
    check_eq("post_rst_b03.abs", csr_rdata_o, 64'd0);
    step(1'b1, 12'hB00, RD, 64'd0, PM, 32'd0, 1'b0, 14'd0, "post_rst_b00");
    check_eq("post_rst_b00.abs", csr_rdata_o, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_perf_counters.md
Name: csr_perf_counters

Overview:
- Machine-mode counter/performance-monitor CSR bank, directly downstream of the CSR address map: consumes decoded CSR accesses (address, op, data, privilege) from the CSR stage.
- Owns mcycle, minstret and hpm counters 3..16 (0xB00-0xB10) plus their user-mode read-only shadows (0xC00-0xC10).
- Returns read data or illegal-access flag one cycle after each request.
- Counts core events every cycle.

Parameters:
- XLEN, 64, counter and data width
- NB_HPM_EVENTS, 14, number of event counters mapped at 0xB03..0xB10
- NB_RESERVED, 15, read-as-zero counters mapped at 0xB11..0xB1F / 0xC11..0xC1F

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- csr_valid_i  in  1  CSR access request this cycle
- csr_addr_i  in  12  CSR address (riscv::csr_reg_t)
- csr_op_i  in  2  00 read, 01 write, 10 set, 11 clear
- csr_wdata_i  in  XLEN  write/set/clear operand
- priv_lvl_i  in  2  current privilege: 00 U, 01 S, 11 M
- mcounteren_i  in  32  mcounteren value from CSR file
- instret_i  in  1  one instruction retired this cycle
- event_i  in  NB_HPM_EVENTS  event pulses; bit k drives counter 0xB03+k
- csr_rvalid_o  out  1  response valid, one cycle after csr_valid_i
- csr_rdata_o  out  XLEN  old CSR value (pre-write)
- csr_illegal_o  out  1  access rejected; qualifies csr_rvalid_o

Behaviour:
- Reset: all counters 0; csr_rvalid_o=0, csr_rdata_o=0, csr_illegal_o=0. Reset mid-request drops the response and clears any pending write.
- Latency: request in cycle N -> csr_rvalid_o/rdata/illegal registered in N+1. Back-to-back requests are accepted every cycle. No backpressure.
- Counting: mcycle +1 every cycle. minstret +1 when instret_i=1. Event counter k +1 when event_i[k]=1. All counters wrap 2^XLEN-1 -> 0, no flag.
- Read value: csr_rdata_o is the counter value at the start of cycle N, i.e. before cycle N's increment or write.
- Write value: new = wdata (write), old|wdata (set), old&~wdata (clear). The upstream decoder converts csrrs/csrrc with rs1=x0 into a read.
- Write vs increment, same cycle, same counter: the written value wins; that cycle's increment is dropped. Other counters increment normally.
- Address map:
  - 0xB00 mcycle; 0xB02 minstret; 0xB03+k event counter k.
  - 0xB01 and 0xB11-0xB1F read 0, writes ignored, legal in M.
  - 0xC00-0xC1F are read-only shadows of 0xB00-0xB1F. 0xC01 (time) is outside this block and is illegal here.
- Illegal (rdata=0, no state change, illegal=1):
  - address outside 0xB00-0xB1F / 0xC00-0xC1F, or 0xC01
  - 0xBxx from priv below M
  - any non-read op to 0xCxx
  - 0xCxx from priv below M with mcounteren_i[addr[4:0]]=0
- csr_valid_i=0: no access, no state change except counting. csr_rvalid_o=0 next cycle; rdata and illegal go to 0.

Decomposition:
- Add to package riscv: csr_op_t enum (CSR_READ, CSR_WRITE, CSR_SET, CSR_CLEAR), priv_lvl_t enum (PRIV_U, PRIV_S, PRIV_M), localparam NB_HPM_EVENTS=14.
- Sub-module perf_counter: one XLEN counter with inc_i, we_i, wdata_i, q_o. Write has priority over increment. Instantiated 16 times (mcycle, minstret, 14 events).

Test Plan:
- Reset, then 10 idle cycles -> read 0xB00 returns 10 (value at request cycle); read 0xB02 returns 0.
- Write 0xB07 = 0xFFFF_FFFF_FFFF_FFFF in M with event_i[4]=1 that cycle -> next read 0xB07 = 0xFFFF_FFFF_FFFF_FFFF. After one more event pulse -> reads 0 (wrap).
- Set 0xB0B with 0xF0 over value 0x0F, then clear with 0x03 -> reads 0xFF, then 0xFC. rdata on each op returns the old value.
- U-mode read 0xC02 with mcounteren_i=0x4 -> minstret value, illegal=0. Same read with mcounteren_i=0 -> illegal=1, rdata=0.
- U-mode read 0xB00 -> illegal. M-mode write 0xC00 -> illegal, mcycle keeps counting unaffected. M-mode read 0xC01 -> illegal. M-mode read 0xB15 -> 0, legal.
- Assert rst while a write to 0xB03 is issued -> all counters 0, rvalid=0 next cycle, written value not applied.
